slope_peak_detector: RTL and testbench

SLOPE_PEAK_DETECTOR -- requirements
Module: slope_peak_detector

---
 rtl/peak_pkg.sv | 16 +
 rtl/slope_window.sv | 63 ++++++
 rtl/slope_peak_detector.sv | 151 +++++++++++++++
 tb/tb_slope_peak_detector.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peak_pkg.sv
// Default parameter values and width helper shared by the slope peak detector files.
package peak_pkg;

    localparam int W_DEF        = 10;
    localparam int HALF_DEF     = 64;
    localparam int RISE_MIN_DEF = 51;
    localparam int FALL_MIN_DEF = 51;
    localparam int REFRACT_DEF  = 100;
    localparam int LED_CYC_DEF  = 2000000;

    // Bits needed to hold values 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/slope_window.sv
// Slope-bit shift window with incrementally maintained half counts and a primed flag.
// Outputs are the post-update values for the current shift, so the caller can act on them at the same edge.
module slope_window
    import peak_pkg::*;
#(
    parameter int HALF = HALF_DEF,
    parameter int CW   = cnt_width(HALF_DEF)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          shift_i,
    input  logic          bit_i,
    output logic [CW-1:0] rise_nxt_o,
    output logic [CW-1:0] fall_nxt_o,
    output logic          primed_nxt_o
);

    localparam int SHW = cnt_width(2 * HALF);
    localparam logic [SHW-1:0] FILL_FULL = SHW'(2 * HALF);
    localparam logic [SHW-1:0] FILL_HALF = SHW'(HALF);

    logic [2*HALF-1:0] win_q, win_d;
    logic [CW-1:0]     rise_q, rise_d;
    logic [CW-1:0]     fall_q, fall_d;
    logic [SHW-1:0]    fill_q, fill_d;
    logic              drop_zero;

    // A zero leaving the newer half only counts once real bits have reached that position.
    always_comb begin
        win_d     = win_q;
        rise_d    = rise_q;
        fall_d    = fall_q;
        fill_d    = fill_q;
        drop_zero = (fill_q >= FILL_HALF) && !win_q[HALF-1];
        if (shift_i) begin
            win_d  = {win_q[2*HALF-2:0], bit_i};
            rise_d = rise_q + CW'(win_q[HALF-1]) - CW'(win_q[2*HALF-1]);
            fall_d = fall_q + CW'(!bit_i) - CW'(drop_zero);
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + SHW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            fill_q <= '0;
        end else begin
            win_q  <= win_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            fill_q <= fill_d;
        end
    end

    assign rise_nxt_o   = rise_d;
    assign fall_nxt_o   = fall_d;
    assign primed_nxt_o = (fill_d == FILL_FULL);

endmodule

// File: rtl/slope_peak_detector.sv
// Peak detector on a stream of filtered samples: a rising run followed by a falling run marks a peak,
// with refractory blanking, a stretched LED, a wrapping peak counter and the sample interval between peaks.
module slope_peak_detector
    import peak_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int HALF     = HALF_DEF,
    parameter int RISE_MIN = RISE_MIN_DEF,
    parameter int FALL_MIN = FALL_MIN_DEF,
    parameter int REFRACT  = REFRACT_DEF,
    parameter int LED_CYC  = LED_CYC_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sample_valid,
    input  logic [W-1:0] sample,
    input  logic         clear_count,
    output logic         peak_pulse,
    output logic         peak_led,
    output logic [7:0]   peak_count,
    output logic [15:0]  interval,
    output logic         interval_valid
);

    localparam int CW = cnt_width(HALF);
    localparam int RW = cnt_width(REFRACT);
    localparam int LW = cnt_width(LED_CYC);

    localparam logic [CW-1:0] RISE_THR  = CW'(RISE_MIN);
    localparam logic [CW-1:0] FALL_THR  = CW'(FALL_MIN);
    localparam logic [RW-1:0] REFR_LOAD = RW'(REFRACT);
    localparam logic [LW-1:0] LED_LOAD  = LW'(LED_CYC);

    logic [W-1:0]  prev_q, prev_d;
    logic          have_prev_q, have_prev_d;
    logic [RW-1:0] refr_q, refr_d;
    logic [LW-1:0] led_q, led_d;
    logic [15:0]   gap_q, gap_d;
    logic          seen_q, seen_d;
    logic [7:0]    count_q, count_d;
    logic [15:0]   interval_q, interval_d;
    logic          pulse_q, pulse_d;
    logic          ivalid_q, ivalid_d;

    logic          shift;
    logic          slope_bit;
    logic          peak;
    logic [CW-1:0] rise_nxt;
    logic [CW-1:0] fall_nxt;
    logic          primed_nxt;
    logic [15:0]   gap_inc;

    // The very first accepted sample has nothing to compare against, so it only seeds prev_q.
    assign shift     = sample_valid && have_prev_q;
    assign slope_bit = (sample > prev_q);

    slope_window #(
        .HALF (HALF),
        .CW   (CW)
    ) u_window (
        .clk_i        (clk),
        .rst_ni       (reset),
        .shift_i      (shift),
        .bit_i        (slope_bit),
        .rise_nxt_o   (rise_nxt),
        .fall_nxt_o   (fall_nxt),
        .primed_nxt_o (primed_nxt)
    );

    assign peak    = sample_valid && primed_nxt && (rise_nxt >= RISE_THR)
                     && (fall_nxt >= FALL_THR) && (refr_q == '0);
    assign gap_inc = (gap_q == 16'hFFFF) ? gap_q : gap_q + 16'd1;

    always_comb begin
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        refr_d      = refr_q;
        led_d       = led_q;
        gap_d       = gap_q;
        seen_d      = seen_q;
        count_d     = count_q;
        interval_d  = interval_q;
        pulse_d     = peak;
        ivalid_d    = 1'b0;

        if (sample_valid) begin
            prev_d      = sample;
            have_prev_d = 1'b1;
            gap_d       = peak ? 16'd0 : gap_inc;
            if (peak) begin
                refr_d = REFR_LOAD;
            end else if (refr_q != '0) begin
                refr_d = refr_q - RW'(1);
            end
        end

        if (peak) begin
            led_d = LED_LOAD;
        end else if (led_q != '0) begin
            led_d = led_q - LW'(1);
        end

        // The first peak has no predecessor, so it only arms interval reporting.
        if (peak) begin
            seen_d = 1'b1;
            if (seen_q) begin
                interval_d = gap_inc;
                ivalid_d   = 1'b1;
            end
        end

        if (peak) begin
            count_d = clear_count ? 8'd1 : count_q + 8'd1;
        end else if (clear_count) begin
            count_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            refr_q      <= '0;
            led_q       <= '0;
            gap_q       <= '0;
            seen_q      <= 1'b0;
            count_q     <= '0;
            interval_q  <= '0;
            pulse_q     <= 1'b0;
            ivalid_q    <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            refr_q      <= refr_d;
            led_q       <= led_d;
            gap_q       <= gap_d;
            seen_q      <= seen_d;
            count_q     <= count_d;
            interval_q  <= interval_d;
            pulse_q     <= pulse_d;
            ivalid_q    <= ivalid_d;
        end
    end

    assign peak_pulse     = pulse_q;
    assign peak_led       = (led_q != '0);
    assign peak_count     = count_q;
    assign interval       = interval_q;
    assign interval_valid = ivalid_q;

endmodule

// File: tb/tb_slope_peak_detector.sv
// Directed bench for slope_peak_detector: a sample-level reference model checked every cycle,
// plus hand-derived expectations for each scenario.
module tb_slope_peak_detector;

    localparam int W        = 10;
    localparam int HALF     = 8;
    localparam int RISE_MIN = 6;
    localparam int FALL_MIN = 6;
    localparam int REFRACT  = 10;
    localparam int LED_CYC  = 20;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         sample_valid = 1'b0;
    logic [W-1:0] sample = '0;
    logic         clear_count = 1'b0;
    logic         peak_pulse;
    logic         peak_led;
    logic [7:0]   peak_count;
    logic [15:0]  interval;
    logic         interval_valid;

    always #5 clk = ~clk;

    slope_peak_detector #(
        .W        (W),
        .HALF     (HALF),
        .RISE_MIN (RISE_MIN),
        .FALL_MIN (FALL_MIN),
        .REFRACT  (REFRACT),
        .LED_CYC  (LED_CYC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .sample         (sample),
        .clear_count    (clear_count),
        .peak_pulse     (peak_pulse),
        .peak_led       (peak_led),
        .peak_count     (peak_count),
        .interval       (interval),
        .interval_valid (interval_valid)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: keeps the slope history as a queue and recounts the halves on every sample.
    int m_prev, m_refr, m_led, m_gap, m_cnt, m_interval;
    bit m_have, m_seen;
    bit m_bits[$];
    bit exp_pulse = 0, exp_led = 0, exp_ival = 0;
    int exp_cnt = 0, exp_int = 0;

    task automatic model_clear();
        m_prev = 0; m_refr = 0; m_led = 0; m_gap = 0; m_cnt = 0; m_interval = 0;
        m_have = 0; m_seen = 0;
        m_bits.delete();
        exp_pulse = 0; exp_led = 0; exp_ival = 0; exp_cnt = 0; exp_int = 0;
    endtask

    task automatic model_step();
        bit peak;
        int rise, fall;
        peak = 0;
        exp_ival = 0;
        if (sample_valid) begin
            if (m_have) begin
                m_bits.push_back(int'(sample) > m_prev);
                if (m_bits.size() > 2 * HALF) void'(m_bits.pop_front());
            end
            m_prev = int'(sample);
            m_have = 1;
            if (m_bits.size() == 2 * HALF) begin
                rise = 0;
                fall = 0;
                for (int i = 0; i < HALF; i++) begin
                    rise += int'(m_bits[i]);
                    fall += (m_bits[HALF + i] == 1'b0) ? 1 : 0;
                end
                peak = (rise >= RISE_MIN) && (fall >= FALL_MIN) && (m_refr == 0);
            end
            if (peak) m_refr = REFRACT;
            else if (m_refr > 0) m_refr--;
            if (peak) begin
                if (m_seen) begin
                    m_interval = (m_gap + 1 > 65535) ? 65535 : m_gap + 1;
                    exp_ival = 1;
                end
                m_seen = 1;
                m_gap = 0;
            end else if (m_gap < 65535) begin
                m_gap++;
            end
        end
        if (peak) m_cnt = clear_count ? 1 : (m_cnt + 1) % 256;
        else if (clear_count) m_cnt = 0;
        if (peak) m_led = LED_CYC;
        else if (m_led > 0) m_led--;
        exp_pulse = peak;
        exp_led = (m_led != 0);
        exp_cnt = m_cnt;
        exp_int = m_interval;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_clear();
        else model_step();
    end

    int last_acc = 0;
    always @(posedge clk) begin
        if (reset && sample_valid) last_acc <= int'(sample);
    end

    int pulse_total = 0, ival_total = 0, led_cycles = 0, pulse_val = -1;

    always @(negedge clk) begin
        chk("peak_pulse", peak_pulse, exp_pulse);
        chk("peak_led", peak_led, exp_led);
        chk("peak_count", peak_count, exp_cnt);
        chk("interval", interval, exp_int);
        chk("interval_valid", interval_valid, exp_ival);
        if (peak_pulse) begin
            pulse_total++;
            pulse_val = last_acc;
        end
        if (interval_valid) ival_total++;
        if (peak_led) led_cycles++;
    end

    task automatic drive(input int v, input bit vld, input bit clr);
        @(posedge clk);
        #1;
        sample_valid = vld;
        sample = W'(v);
        clear_count = clr;
    endtask

    task automatic send(input int v, input int gaps);
        drive(v, 1'b1, 1'b0);
        repeat (gaps) drive(1023, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1023, 1'b0, 1'b0);
    endtask

    task automatic seq_up(input int from, input int to, input int step, input int gaps);
        for (int v = from; v <= to; v += step) send(v, gaps);
    endtask

    task automatic seq_dn(input int from, input int to, input int step, input int gaps);
        for (int v = from; v >= to; v -= step) send(v, gaps);
    endtask

    task automatic triangle();
        seq_up(0, 170, 10, 0);
        seq_dn(160, 0, 10, 0);
    endtask

    task automatic period16();
        seq_up(10, 80, 10, 0);
        seq_dn(70, 0, 10, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        sample_valid = 1'b0;
        clear_count = 1'b0;
        sample = '0;
        #1;
        chk("rst_pulse", peak_pulse, 0);
        chk("rst_led", peak_led, 0);
        chk("rst_count", peak_count, 0);
        chk("rst_interval", interval, 0);
        chk("rst_ivalid", interval_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    int p0, i0, l0;

    initial begin
        // Slow ramp, valid every third cycle: peak on the sixth falling sample (110).
        do_reset();
        p0 = pulse_total; i0 = ival_total;
        seq_up(0, 170, 10, 2);
        seq_dn(160, 0, 10, 2);
        idle(5);
        chk("ramp_pulses", pulse_total - p0, 1);
        chk("ramp_peak_sample", pulse_val, 110);
        chk("ramp_count", peak_count, 1);
        chk("ramp_ivalid", ival_total - i0, 0);

        // Two triangles with apexes 40 samples apart.
        do_reset();
        p0 = pulse_total; i0 = ival_total;
        triangle();
        repeat (5) send(0, 0);
        triangle();
        idle(5);
        chk("tri2_pulses", pulse_total - p0, 2);
        chk("tri2_count", peak_count, 2);
        chk("tri2_interval", interval, 40);
        chk("tri2_ivalid", ival_total - i0, 1);

        // Noisy apex inside the refractory window, then a fresh apex once it has expired.
        do_reset();
        p0 = pulse_total;
        seq_up(0, 170, 10, 0);
        seq_dn(160, 110, 10, 0);
        send(120, 0);
        seq_dn(100, 0, 10, 0);
        idle(3);
        chk("noisy_pulses", pulse_total - p0, 1);
        seq_up(10, 170, 10, 0);
        seq_dn(160, 0, 10, 0);
        idle(5);
        chk("refr_pulses", pulse_total - p0, 2);
        chk("refr_interval", interval, 35);
        chk("refr_count", peak_count, 2);

        // Flat input never peaks.
        do_reset();
        p0 = pulse_total; l0 = led_cycles;
        repeat (50) send(300, 0);
        idle(3);
        chk("flat_pulses", pulse_total - p0, 0);
        chk("flat_led_cycles", led_cycles - l0, 0);
        chk("flat_count", peak_count, 0);

        // Reset during descent with the LED lit, then a fresh 17-sample prime.
        seq_up(0, 170, 10, 0);
        seq_dn(160, 100, 10, 0);
        send(90, 0);
        chk("pre_rst_led", peak_led, 1);
        chk("pre_rst_count", peak_count, 1);
        do_reset();
        p0 = pulse_total; i0 = ival_total;
        seq_up(0, 90, 10, 0);
        seq_dn(80, 20, 10, 0);
        idle(5);
        chk("prime_pulses", pulse_total - p0, 1);
        chk("prime_peak_sample", pulse_val, 20);
        chk("prime_count", peak_count, 1);
        chk("prime_interval", interval, 0);
        chk("prime_ivalid", ival_total - i0, 0);

        // Counter wrap, clear coinciding with a peak, and interval saturation.
        do_reset();
        p0 = pulse_total;
        send(0, 0);
        for (int p = 0; p < 300; p++) begin
            period16();
            if (pulse_total - p0 >= 255) break;
        end
        idle(3);
        chk("wrap_pulses", pulse_total - p0, 255);
        chk("count_255", peak_count, 255);
        period16();
        idle(3);
        chk("count_wrap", peak_count, 0);
        period16();
        idle(3);
        chk("count_after_wrap", peak_count, 1);
        seq_up(10, 170, 10, 0);
        seq_dn(160, 120, 10, 0);
        drive(110, 1'b1, 1'b1);
        drive(100, 1'b1, 1'b0);
        seq_dn(90, 0, 10, 0);
        idle(3);
        chk("clear_with_peak", peak_count, 1);
        i0 = ival_total;
        repeat (70000) send(0, 0);
        seq_up(10, 170, 10, 0);
        seq_dn(160, 0, 10, 0);
        idle(5);
        chk("gap_sat_interval", interval, 65535);
        chk("gap_sat_count", peak_count, 2);
        chk("gap_sat_ivalid", ival_total - i0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
